sha256_msg_schedule: RTL and testbench
======================================

Name: sha256_msg_schedule

Overview:
- Upstream neighbour of the SHA-256 compression round engine.
- Accepts one 512-bit padded message block over a valid/ready handshake and expands it into the 64-word message schedule W_0..W_63.
- Presents one W_t / K_t pair per cycle with a round strobe that drives the engine's per-round enable. Pulses a block-done strobe that drives the engine's digest update.

Parameters:
- None. Round count is fixed at 64 and the K table is fixed by FIPS 180-4.

Ports:
- clk  in  1  clock
- reset_n  in  1  asynchronous, active-low reset
- abort  in  1  synchronous abandon of the current block
- block_valid  in  1  block_data/block_last valid
- block_ready  out  1  block accepted when block_valid & block_ready
- block_data  in  512  padded block; word 0 = block_data[511:480]
- block_last  in  1  block is the final block of the message
- round_valid  out  1  W_t/K_t valid this cycle (round enable to engine)
- round_idx  out  6  t of current round
- w_out  out  32  W_t
- k_out  out  32  K_t
- sched_done  out  1  one-cycle pulse after round 63 (digest update strobe)
- done_last  out  1  copy of captured block_last, valid with sched_done

Behaviour:
- Storage: 16 x 32-bit window w[0..15]; w[k] = W_(t+k). 6-bit round counter. 1-bit captured last flag. 2-bit FSM.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - block_ready=1.
  - On handshake: w[k] <= block_data[511-32k -: 32], counter <= 0, last flag <= block_last, go to RUN.
- RUN:
  - round_valid=1, round_idx=counter, w_out=w[0], k_out=K[counter].
  - Every cycle, shift the window: w[k] <= w[k+1] for k=0..14.
  - w[15] <= σ1(w[14]) + w[9] + σ0(w[1]) + w[0], modulo 2^32.
  - σ0(x) = ROTR7 ^ ROTR18 ^ SHR3. σ1(x) = ROTR17 ^ ROTR19 ^ SHR10.
  - counter increments; at counter==63 go to DONE.
- DONE:
  - Lasts one cycle.
  - sched_done=1, done_last=last flag; go to IDLE.
- Timing:
  - Handshake at edge A → rounds 0..63 on cycles A+1..A+64 → sched_done on A+65 → block_ready high from A+66.
  - Throughput 66 cycles/block.
- Output timing: w_out, k_out and round_valid derive only from registers, so no input-to-output combinational path. The engine samples them at the same edge that advances its state.
- K ROM: 64-entry combinational case on round_idx with the standard SHA-256 constants, 0x428a2f98 .. 0xc67178f2.
- Outputs outside RUN:
  - round_valid=0.
  - w_out and k_out forced to 0.
  - round_idx holds the counter value.
- sched_done and done_last are 0 outside DONE.
- block_ready is 0 in RUN and DONE. block_valid in those states is ignored and does not need to be held low.
- abort:
  - In RUN or DONE: next state IDLE, no sched_done, counter <= 0.
  - In IDLE: abort takes priority over a simultaneous handshake; the block is not accepted.
- Reset (async, any time, including mid-block):
  - State IDLE, window, counter and last flag cleared.
  - All outputs 0 except block_ready, which is 1 after reset.
  - A partially processed block is discarded.
- Wrap-around: counter is never used past 63. No mod-64 reuse of the window.

Test Plan:
1. Single-block "abc" (block_data = 0x61626380, 13 zero words, 0x00000000, 0x00000018) → expected outputs:
   - w_out = 61626380 at round 0, 00000018 at round 15, 61626380 at round 16, 000f0000 at round 17, 7da86405 at round 18, 600003c6 at round 19.
   - k_out = 428a2f98 at round 0 and c67178f2 at round 63.
   - sched_done exactly 65 cycles after the handshake with done_last=1.
2. Integration with the compression engine for "abc" (engine init before the block, digest sampled after sched_done) → digest ba7816bf 8f01cfea 414140de 5dae2223 b00361a3 96177a9c b410ff61 f20015ad.
3. Back-to-back blocks with block_valid held high → second handshake exactly 66 cycles after the first; block_ready low for the 65 intervening cycles; round_valid high for exactly 64 cycles per block.
4. Assert abort at round 30 → round_valid drops next cycle; no sched_done; block_ready=1. A new "abc" block then produces the correct schedule from round 0.
5. Pulse reset_n low mid-RUN, asynchronous to clk → outputs immediately round_valid=0, sched_done=0, block_ready=1 (while reset is asserted). After release, a fresh block is scheduled correctly.
6. Random 512-bit blocks (1000 iterations) against a reference-model W expansion → every w_out/round_idx pair matches; round_idx counts 0..63 with no gaps.

Source files
------------

// File: rtl/sha256_msg_schedule_if.sv
// rtl/sha256_msg_schedule_if.sv - block input / round output bundle between message source, schedule and round engine
interface sha256_msg_schedule_if;
    logic         abort;
    logic         block_valid;
    logic         block_ready;
    logic [511:0] block_data;
    logic         block_last;
    logic         round_valid;
    logic [5:0]   round_idx;
    logic [31:0]  w_out;
    logic [31:0]  k_out;
    logic         sched_done;
    logic         done_last;

    modport master (
        output abort, block_valid, block_data, block_last,
        input  block_ready, round_valid, round_idx, w_out, k_out, sched_done, done_last
    );

    modport slave (
        input  abort, block_valid, block_data, block_last,
        output block_ready, round_valid, round_idx, w_out, k_out, sched_done, done_last
    );
endinterface

// File: rtl/sha256_msg_schedule.sv
// rtl/sha256_msg_schedule.sv - SHA-256 message schedule: expands a 512-bit block into W_0..W_63 with K_t
// A 16-word sliding window holds W_t..W_t+15; w_q[0] is always the current round's word.
module sha256_msg_schedule (
    input  logic                     clk,
    input  logic                     reset_n,
    sha256_msg_schedule_if.slave     bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] w_q [16];
    logic [31:0] w_d [16];
    logic [5:0]  cnt_q, cnt_d;
    logic        last_q, last_d;
    logic [31:0] k_rom;

    function automatic logic [31:0] ssig0(input logic [31:0] x);
        return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ {3'b000, x[31:3]};
    endfunction

    function automatic logic [31:0] ssig1(input logic [31:0] x);
        return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ {10'b0, x[31:10]};
    endfunction

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            last_q  <= 1'b0;
            for (int k = 0; k < 16; k++) begin
                w_q[k] <= '0;
            end
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            last_q  <= last_d;
            w_q     <= w_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        last_d  = last_q;
        w_d     = w_q;
        case (state_q)
            IDLE: begin
                // abort outranks a simultaneous handshake
                if (!bus.abort && bus.block_valid) begin
                    for (int k = 0; k < 16; k++) begin
                        w_d[k] = bus.block_data[511 - 32*k -: 32];
                    end
                    cnt_d   = '0;
                    last_d  = bus.block_last;
                    state_d = RUN;
                end
            end
            RUN: begin
                for (int k = 0; k < 15; k++) begin
                    w_d[k] = w_q[k+1];
                end
                w_d[15] = ssig1(w_q[14]) + w_q[9] + ssig0(w_q[1]) + w_q[0];
                if (bus.abort) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                end else if (cnt_q == 6'd63) begin
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + 6'd1;
                end
            end
            DONE: begin
                if (bus.abort) begin
                    cnt_d = '0;
                end
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        k_rom = '0;
        case (cnt_q)
            6'd0:  k_rom = 32'h428a2f98; 6'd1:  k_rom = 32'h71374491; 6'd2:  k_rom = 32'hb5c0fbcf; 6'd3:  k_rom = 32'he9b5dba5;
            6'd4:  k_rom = 32'h3956c25b; 6'd5:  k_rom = 32'h59f111f1; 6'd6:  k_rom = 32'h923f82a4; 6'd7:  k_rom = 32'hab1c5ed5;
            6'd8:  k_rom = 32'hd807aa98; 6'd9:  k_rom = 32'h12835b01; 6'd10: k_rom = 32'h243185be; 6'd11: k_rom = 32'h550c7dc3;
            6'd12: k_rom = 32'h72be5d74; 6'd13: k_rom = 32'h80deb1fe; 6'd14: k_rom = 32'h9bdc06a7; 6'd15: k_rom = 32'hc19bf174;
            6'd16: k_rom = 32'he49b69c1; 6'd17: k_rom = 32'hefbe4786; 6'd18: k_rom = 32'h0fc19dc6; 6'd19: k_rom = 32'h240ca1cc;
            6'd20: k_rom = 32'h2de92c6f; 6'd21: k_rom = 32'h4a7484aa; 6'd22: k_rom = 32'h5cb0a9dc; 6'd23: k_rom = 32'h76f988da;
            6'd24: k_rom = 32'h983e5152; 6'd25: k_rom = 32'ha831c66d; 6'd26: k_rom = 32'hb00327c8; 6'd27: k_rom = 32'hbf597fc7;
            6'd28: k_rom = 32'hc6e00bf3; 6'd29: k_rom = 32'hd5a79147; 6'd30: k_rom = 32'h06ca6351; 6'd31: k_rom = 32'h14292967;
            6'd32: k_rom = 32'h27b70a85; 6'd33: k_rom = 32'h2e1b2138; 6'd34: k_rom = 32'h4d2c6dfc; 6'd35: k_rom = 32'h53380d13;
            6'd36: k_rom = 32'h650a7354; 6'd37: k_rom = 32'h766a0abb; 6'd38: k_rom = 32'h81c2c92e; 6'd39: k_rom = 32'h92722c85;
            6'd40: k_rom = 32'ha2bfe8a1; 6'd41: k_rom = 32'ha81a664b; 6'd42: k_rom = 32'hc24b8b70; 6'd43: k_rom = 32'hc76c51a3;
            6'd44: k_rom = 32'hd192e819; 6'd45: k_rom = 32'hd6990624; 6'd46: k_rom = 32'hf40e3585; 6'd47: k_rom = 32'h106aa070;
            6'd48: k_rom = 32'h19a4c116; 6'd49: k_rom = 32'h1e376c08; 6'd50: k_rom = 32'h2748774c; 6'd51: k_rom = 32'h34b0bcb5;
            6'd52: k_rom = 32'h391c0cb3; 6'd53: k_rom = 32'h4ed8aa4a; 6'd54: k_rom = 32'h5b9cca4f; 6'd55: k_rom = 32'h682e6ff3;
            6'd56: k_rom = 32'h748f82ee; 6'd57: k_rom = 32'h78a5636f; 6'd58: k_rom = 32'h84c87814; 6'd59: k_rom = 32'h8cc70208;
            6'd60: k_rom = 32'h90befffa; 6'd61: k_rom = 32'ha4506ceb; 6'd62: k_rom = 32'hbef9a3f7; 6'd63: k_rom = 32'hc67178f2;
            default: k_rom = '0;
        endcase
    end

    // All outputs decode registered state only, so the engine sees no input-to-output path.
    assign bus.block_ready = (state_q == IDLE);
    assign bus.round_valid = (state_q == RUN);
    assign bus.round_idx   = cnt_q;
    assign bus.w_out       = (state_q == RUN) ? w_q[0] : '0;
    assign bus.k_out       = (state_q == RUN) ? k_rom : '0;
    assign bus.sched_done  = (state_q == DONE);
    assign bus.done_last   = (state_q == DONE) && last_q;
endmodule

// File: tb/tb_sha256_msg_schedule.sv
// tb/tb_sha256_msg_schedule.sv - scoreboard bench for the SHA-256 message schedule
module tb_sha256_msg_schedule;
    logic clk = 1'b0;
    logic reset_n = 1'b1;
    always #5 clk = ~clk;

    sha256_msg_schedule_if bus ();
    sha256_msg_schedule dut (.clk(clk), .reset_n(reset_n), .bus(bus));

    localparam logic [31:0] KT [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };
    localparam logic [31:0] IV [8] = '{32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
                                       32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};
    localparam logic [31:0] ABC_DIGEST [8] = '{32'hba7816bf, 32'h8f01cfea, 32'h414140de, 32'h5dae2223,
                                               32'hb00361a3, 32'h96177a9c, 32'hb410ff61, 32'hf20015ad};
    localparam logic [511:0] ABC = {32'h61626380, 448'b0, 32'h00000018};

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int exp_done_cyc = -1;
    logic exp_last = 1'b0;
    logic [31:0] sb_w [$];
    logic [5:0]  sb_i [$];
    int hs_count = 0, last_hs_cyc = 0, hs_gap = 0;
    int rv_total = 0, rdy_low_total = 0, done_total = 0;
    int rv_at_hs = 0, rdy_at_hs = 0, hs_rv_delta = 0, hs_rdy_delta = 0;
    logic [5:0]  last_idx = 6'd0;
    logic [31:0] obs_w [64];
    logic [31:0] obs_k [64];
    logic [31:0] hh [8];
    logic [31:0] st [8];
    bit eng_on = 1'b0;

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    task automatic ref_sched(input logic [511:0] b, output logic [31:0] w [64]);
        logic [31:0] s0, s1;
        for (int t = 0; t < 16; t++) w[t] = b[511 - 32*t -: 32];
        for (int t = 16; t < 64; t++) begin
            s0 = rotr(w[t-15], 7) ^ rotr(w[t-15], 18) ^ (w[t-15] >> 3);
            s1 = rotr(w[t-2], 17) ^ rotr(w[t-2], 19) ^ (w[t-2] >> 10);
            w[t] = s1 + w[t-7] + s0 + w[t-16];
        end
    endtask

    task automatic eng_round(input logic [31:0] w, input logic [31:0] k);
        logic [31:0] t1, t2;
        t1 = st[7] + (rotr(st[4], 6) ^ rotr(st[4], 11) ^ rotr(st[4], 25))
           + ((st[4] & st[5]) ^ (~st[4] & st[6])) + k + w;
        t2 = (rotr(st[0], 2) ^ rotr(st[0], 13) ^ rotr(st[0], 22))
           + ((st[0] & st[1]) ^ (st[0] & st[2]) ^ (st[1] & st[2]));
        st[7] = st[6]; st[6] = st[5]; st[5] = st[4]; st[4] = st[3] + t1;
        st[3] = st[2]; st[2] = st[1]; st[1] = st[0]; st[0] = t1 + t2;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // One clock: push expectations on a handshake, then sample at the falling edge and score.
    task automatic cycle();
        logic [31:0] wr [64];
        logic [31:0] ew;
        logic [5:0]  ei;
        logic        exp_run;
        if (bus.block_valid && bus.block_ready && !bus.abort && reset_n) begin
            ref_sched(bus.block_data, wr);
            for (int t = 0; t < 64; t++) begin
                sb_w.push_back(wr[t]);
                sb_i.push_back(6'(t));
            end
            exp_done_cyc = cyc + 65;
            exp_last     = bus.block_last;
            hs_gap       = cyc - last_hs_cyc;
            last_hs_cyc  = cyc;
            hs_rv_delta  = rv_total - rv_at_hs;
            hs_rdy_delta = rdy_low_total - rdy_at_hs;
            rv_at_hs     = rv_total;
            rdy_at_hs    = rdy_low_total;
            hs_count++;
            if (eng_on) for (int i = 0; i < 8; i++) st[i] = hh[i];
        end
        @(negedge clk);
        cyc++;
        exp_run = (sb_w.size() != 0);
        chk1("round_valid", bus.round_valid, exp_run);
        chk1("block_ready", bus.block_ready, !exp_run && (cyc != exp_done_cyc));
        chk1("sched_done", bus.sched_done, cyc == exp_done_cyc);
        chk1("done_last", bus.done_last, (cyc == exp_done_cyc) ? exp_last : 1'b0);
        if (bus.round_valid) rv_total++;
        if (!bus.block_ready) rdy_low_total++;
        if (bus.sched_done) done_total++;
        if (bus.round_valid && exp_run) begin
            ew = sb_w.pop_front();
            ei = sb_i.pop_front();
            chk("round_idx", 32'(bus.round_idx), 32'(ei));
            chk("w_out", bus.w_out, ew);
            chk("k_out", bus.k_out, KT[ei]);
            obs_w[ei] = bus.w_out;
            obs_k[ei] = bus.k_out;
            last_idx  = ei;
            if (eng_on) eng_round(bus.w_out, bus.k_out);
        end else begin
            chk("w_out_idle", bus.w_out, 32'h0);
            chk("k_out_idle", bus.k_out, 32'h0);
        end
        if (bus.sched_done && eng_on) for (int i = 0; i < 8; i++) hh[i] = hh[i] + st[i];
    endtask

    task automatic wait_hs(input int budget);
        int start = hs_count;
        int n = 0;
        while (hs_count == start && n < budget) begin
            cycle();
            n++;
        end
        chk1("handshake_timeout", hs_count != start, 1'b1);
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while ((sb_w.size() != 0 || cyc < exp_done_cyc) && n < budget) begin
            cycle();
            n++;
        end
        chk1("drain_timeout", n < budget, 1'b1);
    endtask

    task automatic rand_block(output logic [511:0] b);
        for (int j = 0; j < 16; j++) b[511 - 32*j -: 32] = $urandom();
    endtask

    task automatic flush_sb();
        sb_w.delete();
        sb_i.delete();
        exp_done_cyc = -1;
    endtask

    initial begin
        logic [511:0] blk;
        int n;
        bus.abort = 1'b0;
        bus.block_valid = 1'b0;
        bus.block_data = '0;
        bus.block_last = 1'b0;
        #1 reset_n = 1'b0;
        #1;
        chk1("rst_block_ready", bus.block_ready, 1'b1);
        chk1("rst_round_valid", bus.round_valid, 1'b0);
        chk1("rst_sched_done", bus.sched_done, 1'b0);
        chk1("rst_done_last", bus.done_last, 1'b0);
        chk("rst_round_idx", 32'(bus.round_idx), 32'h0);
        chk("rst_w_out", bus.w_out, 32'h0);
        chk("rst_k_out", bus.k_out, 32'h0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;

        // "abc" with a compression-engine model riding on the round strobe
        for (int i = 0; i < 8; i++) hh[i] = IV[i];
        eng_on = 1'b1;
        bus.block_data = ABC;
        bus.block_last = 1'b1;
        bus.block_valid = 1'b1;
        wait_hs(10);
        bus.block_valid = 1'b0;
        drain(100);
        eng_on = 1'b0;
        chk("abc_w0", obs_w[0], 32'h61626380);
        chk("abc_w15", obs_w[15], 32'h00000018);
        chk("abc_w16", obs_w[16], 32'h61626380);
        chk("abc_w17", obs_w[17], 32'h000f0000);
        chk("abc_w18", obs_w[18], 32'h7da86405);
        chk("abc_w19", obs_w[19], 32'h600003c6);
        chk("abc_k0", obs_k[0], 32'h428a2f98);
        chk("abc_k63", obs_k[63], 32'hc67178f2);
        chk("abc_done_count", 32'(done_total), 32'd1);
        for (int i = 0; i < 8; i++) chk("abc_digest", hh[i], ABC_DIGEST[i]);

        // back-to-back random blocks with block_valid held high
        bus.block_last = 1'b0;
        bus.block_valid = 1'b1;
        for (int it = 0; it < 1000; it++) begin
            rand_block(blk);
            bus.block_data = blk;
            bus.block_last = 1'($urandom_range(0, 1));
            wait_hs(80);
            if (it > 0) begin
                chk("b2b_gap", 32'(hs_gap), 32'd66);
                chk("b2b_round_valid_cycles", 32'(hs_rv_delta), 32'd64);
                chk("b2b_ready_low_cycles", 32'(hs_rdy_delta), 32'd65);
            end
        end
        bus.block_valid = 1'b0;
        drain(100);
        chk("b2b_done_count", 32'(done_total), 32'd1001);

        // abort at round 30, then abort beating a handshake in IDLE
        bus.block_data = ABC;
        bus.block_valid = 1'b1;
        wait_hs(10);
        bus.block_valid = 1'b0;
        n = 0;
        while (last_idx != 6'd30 && n < 80) begin
            cycle();
            n++;
        end
        chk("abort_reach_r30", 32'(last_idx), 32'd30);
        bus.abort = 1'b1;
        flush_sb();
        cycle();
        bus.abort = 1'b0;
        chk1("abort_round_valid", bus.round_valid, 1'b0);
        chk1("abort_block_ready", bus.block_ready, 1'b1);
        repeat (70) cycle();
        chk("abort_no_done", 32'(done_total), 32'd1001);
        n = hs_count;
        bus.block_valid = 1'b1;
        bus.abort = 1'b1;
        repeat (3) cycle();
        chk("abort_beats_hs", 32'(hs_count), 32'(n));
        bus.abort = 1'b0;
        for (int t = 0; t < 64; t++) obs_w[t] = '0;
        wait_hs(10);
        bus.block_valid = 1'b0;
        drain(100);
        chk("post_abort_w0", obs_w[0], 32'h61626380);
        chk("post_abort_w17", obs_w[17], 32'h000f0000);
        chk("post_abort_w19", obs_w[19], 32'h600003c6);

        // asynchronous reset in the middle of a block
        rand_block(blk);
        bus.block_data = blk;
        bus.block_valid = 1'b1;
        wait_hs(10);
        bus.block_valid = 1'b0;
        repeat (20) cycle();
        #2 reset_n = 1'b0;
        #1;
        flush_sb();
        chk1("arst_round_valid", bus.round_valid, 1'b0);
        chk1("arst_sched_done", bus.sched_done, 1'b0);
        chk1("arst_block_ready", bus.block_ready, 1'b1);
        chk("arst_w_out", bus.w_out, 32'h0);
        @(posedge clk);
        #1;
        chk1("arst_hold_round_valid", bus.round_valid, 1'b0);
        chk1("arst_hold_block_ready", bus.block_ready, 1'b1);
        @(negedge clk);
        #2 reset_n = 1'b1;
        for (int t = 0; t < 64; t++) obs_w[t] = '0;
        bus.block_data = ABC;
        bus.block_last = 1'b1;
        bus.block_valid = 1'b1;
        wait_hs(10);
        bus.block_valid = 1'b0;
        drain(100);
        chk("post_rst_w16", obs_w[16], 32'h61626380);
        chk("post_rst_w18", obs_w[18], 32'h7da86405);
        chk("post_rst_done_count", 32'(done_total), 32'd1003);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
